// File: rtl/seg_scan_controller_if.sv
// Control and display bus of the seg_scan_controller: count/scan controls in,
// BCD count and multiplexed seven-segment drive out.
interface seg_scan_controller_if;
    logic        enable;
    logic        advance;
    logic        clear;
    logic        blanking;
    logic        lz_suppress;
    logic [15:0] value;
    logic        wrap;
    logic [6:0]  seg;
    logic [3:0]  digit_en_n;

    modport master (
        output enable, advance, clear, blanking, lz_suppress,
        input  value, wrap, seg, digit_en_n
    );

    modport slave (
        input  enable, advance, clear, blanking, lz_suppress,
        output value, wrap, seg, digit_en_n
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Four-digit BCD event counter driving a time-multiplexed common-anode
// seven-segment display with dead-time, blanking and leading-zero suppression.
module seg_scan_controller #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned STEP       = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    seg_scan_controller_if.slave  bus
);

    localparam int unsigned SC_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    typedef enum logic {ST_GAP, ST_DRIVE} state_t;

    state_t          state_q, state_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic [1:0]      di_q, di_d;
    logic [3:0]      lat_digit_q, lat_digit_d;
    logic            lat_above_q, lat_above_d;
    logic            lat_blank_q, lat_blank_d;
    logic            lat_lz_q, lat_lz_d;
    logic [15:0]     value_q, value_d;
    logic            wrap_q, wrap_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic [4:0]      sum;
    logic            carry;
    logic            last_sc;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    // BCD counter: clear wins, otherwise add STEP with per-digit decimal carry
    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
        sum     = 5'd0;
        carry   = 1'b0;
        if (bus.clear) begin
            value_d = 16'h0000;
        end else if (bus.enable && bus.advance) begin
            for (int i = 0; i < 4; i++) begin
                sum = 5'(value_q[4*i +: 4]) + ((i == 0) ? 5'(STEP) : 5'd0) + 5'(carry);
                if (sum >= 5'd10) begin
                    sum   = sum - 5'd10;
                    carry = 1'b1;
                end else begin
                    carry = 1'b0;
                end
                value_d[4*i +: 4] = sum[3:0];
            end
            wrap_d = carry;
        end
    end

    // Scan sequencing, slot latch and registered display drive
    always_comb begin
        last_sc     = (sc_q == SC_W'(SCAN_DIV - 1));
        sc_d        = last_sc ? '0 : sc_q + SC_W'(1);
        di_d        = last_sc ? di_q + 2'd1 : di_q;
        state_d     = state_q;
        lat_digit_d = lat_digit_q;
        lat_above_d = lat_above_q;
        lat_blank_d = lat_blank_q;
        lat_lz_d    = lat_lz_q;
        an_d        = 4'b1111;
        seg_d       = SEG_BLANK;

        case (state_q)
            ST_GAP:   if (32'(sc_d) >= GAP_CYCLES) state_d = ST_DRIVE;
            ST_DRIVE: if (last_sc)                 state_d = ST_GAP;
            default:                               state_d = ST_GAP;
        endcase

        // Freeze what this slot shows so mid-slot count changes cannot tear it
        if (sc_q == '0) begin
            lat_blank_d = bus.blanking;
            lat_lz_d    = bus.lz_suppress;
            case (di_q)
                2'd0: begin
                    lat_digit_d = value_q[3:0];
                    lat_above_d = (value_q[15:4] == 12'h000);
                end
                2'd1: begin
                    lat_digit_d = value_q[7:4];
                    lat_above_d = (value_q[15:8] == 8'h00);
                end
                2'd2: begin
                    lat_digit_d = value_q[11:8];
                    lat_above_d = (value_q[15:12] == 4'h0);
                end
                default: begin
                    lat_digit_d = value_q[15:12];
                    lat_above_d = 1'b1;
                end
            endcase
        end

        if (state_d == ST_DRIVE && !lat_blank_d) begin
            an_d = ~(4'b0001 << di_d);
            if (!(lat_lz_d && di_d != 2'd0 && lat_digit_d == 4'd0 && lat_above_d))
                seg_d = decode(lat_digit_d);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_GAP;
            sc_q        <= '0;
            di_q        <= 2'd0;
            lat_digit_q <= 4'd0;
            lat_above_q <= 1'b0;
            lat_blank_q <= 1'b0;
            lat_lz_q    <= 1'b0;
            value_q     <= 16'h0000;
            wrap_q      <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= 4'b1111;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            di_q        <= di_d;
            lat_digit_q <= lat_digit_d;
            lat_above_q <= lat_above_d;
            lat_blank_q <= lat_blank_d;
            lat_lz_q    <= lat_lz_d;
            value_q     <= value_d;
            wrap_q      <= wrap_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign bus.value      = value_q;
    assign bus.wrap       = wrap_q;
    assign bus.seg        = seg_q;
    assign bus.digit_en_n = an_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: table-driven counter vectors plus
// hand-written scan, blanking, suppression and reset sequences.
module tb_seg_scan_controller;

    localparam int unsigned SCAN_DIV   = 8;
    localparam int unsigned GAP_CYCLES = 2;
    localparam int unsigned STEP       = 2;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct {
        logic        en;
        logic        adv;
        logic        clr;
        logic [15:0] exp_value;
        logic        exp_wrap;
    } vec_t;

    logic clock;
    logic reset_n;
    int   tests;
    int   fails;
    int   cyc;

    seg_scan_controller_if bus ();

    seg_scan_controller #(
        .SCAN_DIV   (SCAN_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .STEP       (STEP)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edges since reset release: after edge k, slot counter = k%8, digit = (k/8)%4
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        to_bcd = {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic apply(input logic en, input logic adv, input logic clr);
        @(negedge clock);
        bus.enable  = en;
        bus.advance = adv;
        bus.clear   = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        @(negedge clock);
        bus.enable  = 1'b0;
        bus.advance = 1'b0;
        bus.clear   = 1'b0;
    endtask

    task automatic wait_slot(input int d, input int s);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 80 && !hit; n++) begin
            @(posedge clock);
            #1;
            if ((cyc % 8) == s && ((cyc / 8) % 4) == d) hit = 1'b1;
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL wait_slot d%0d sc%0d: not reached within 80 cycles", d, s);
        end
    endtask

    task automatic load_count(input int n);
        apply(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) apply(1'b1, 1'b1, 1'b0);
        idle_inputs();
        chk($sformatf("load %0d", n * 2), bus.value, to_bcd(n * 2));
    endtask

    initial begin
        vec_t vecs [8];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;

        tests = 0;
        fails = 0;
        vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h0002, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0002, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0004, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0002, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0};

        bus.enable      = 1'b0;
        bus.advance     = 1'b0;
        bus.clear       = 1'b0;
        bus.blanking    = 1'b0;
        bus.lz_suppress = 1'b0;
        reset_n         = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("reset anodes", 16'(bus.digit_en_n), 16'hF);
        chk("reset seg",    16'(bus.seg),        16'(SB));
        chk("reset value",  bus.value,           16'h0000);
        chk("reset wrap",   16'(bus.wrap),       16'h0);

        // Idle scan: 2 gap cycles then 6 drive cycles per slot, digit 0..3
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            #1;
            if ((k % 8) >= 2) begin
                exp_an  = ~(4'b0001 << ((k / 8) % 4));
                exp_seg = S0;
            end else begin
                exp_an  = 4'b1111;
                exp_seg = SB;
            end
            chk($sformatf("scan k%0d anodes", k), 16'(bus.digit_en_n), 16'(exp_an));
            chk($sformatf("scan k%0d seg", k),    16'(bus.seg),        16'(exp_seg));
        end

        // Counter vector table
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].en, vecs[i].adv, vecs[i].clr);
            chk($sformatf("vec%0d value", i), bus.value,       vecs[i].exp_value);
            chk($sformatf("vec%0d wrap", i),  16'(bus.wrap),   16'(vecs[i].exp_wrap));
        end

        // 5000 back-to-back advances: 0002..9998, then 0000 with wrap
        for (int i = 1; i <= 5000; i++) begin
            apply(1'b1, 1'b1, 1'b0);
            chk("count value", bus.value,     to_bcd((i * 2) % 10000));
            chk("count wrap",  16'(bus.wrap), 16'(i == 5000));
        end
        apply(1'b0, 1'b1, 1'b0);
        chk("disabled value", bus.value,     16'h0000);
        chk("wrap one cycle", 16'(bus.wrap), 16'h0);

        // Clear has priority over a simultaneous advance
        load_count(62);
        apply(1'b1, 1'b1, 1'b1);
        chk("clr prio value", bus.value,     16'h0000);
        chk("clr prio wrap",  16'(bus.wrap), 16'h0);

        // Leading-zero suppression on 0040
        load_count(20);
        bus.lz_suppress = 1'b1;
        repeat (40) @(posedge clock);
        wait_slot(0, 4);
        chk("lz d0 anodes", 16'(bus.digit_en_n), 16'hE);
        chk("lz d0 seg",    16'(bus.seg),        16'(S0));
        wait_slot(1, 4);
        chk("lz d1 anodes", 16'(bus.digit_en_n), 16'hD);
        chk("lz d1 seg",    16'(bus.seg),        16'(S4));
        wait_slot(2, 4);
        chk("lz d2 anodes", 16'(bus.digit_en_n), 16'hB);
        chk("lz d2 seg",    16'(bus.seg),        16'(SB));
        wait_slot(3, 4);
        chk("lz d3 anodes", 16'(bus.digit_en_n), 16'h7);
        chk("lz d3 seg",    16'(bus.seg),        16'(SB));
        bus.lz_suppress = 1'b0;
        repeat (40) @(posedge clock);
        wait_slot(2, 4);
        chk("nolz d2 anodes", 16'(bus.digit_en_n), 16'hB);
        chk("nolz d2 seg",    16'(bus.seg),        16'(S0));
        wait_slot(3, 4);
        chk("nolz d3 anodes", 16'(bus.digit_en_n), 16'h7);
        chk("nolz d3 seg",    16'(bus.seg),        16'(S0));

        // Blanking asserted mid-slot: current slot keeps driving, next slot dark
        wait_slot(1, 3);
        bus.blanking = 1'b1;
        wait_slot(1, 5);
        chk("blank cur anodes", 16'(bus.digit_en_n), 16'hD);
        chk("blank cur seg",    16'(bus.seg),        16'(S4));
        wait_slot(1, 7);
        chk("blank cur end",    16'(bus.digit_en_n), 16'hD);
        for (int s = 0; s < 8; s++) begin
            @(posedge clock);
            #1;
            chk($sformatf("blank next sc%0d anodes", s), 16'(bus.digit_en_n), 16'hF);
            chk($sformatf("blank next sc%0d seg", s),    16'(bus.seg),        16'(SB));
        end
        bus.blanking = 1'b0;
        wait_slot(3, 4);
        chk("unblank d3 anodes", 16'(bus.digit_en_n), 16'h7);
        chk("unblank d3 seg",    16'(bus.seg),        16'(S0));

        // Advance mid-slot: visible digit holds until the next slot start
        wait_slot(0, 4);
        apply(1'b1, 1'b1, 1'b0);
        idle_inputs();
        chk("mid adv value", bus.value, 16'h0042);
        wait_slot(0, 6);
        chk("mid adv hold seg", 16'(bus.seg), 16'(S0));
        wait_slot(0, 4);
        chk("mid adv new seg",  16'(bus.seg), 16'(S2));

        // Asynchronous reset in DRIVE with value 0356
        load_count(178);
        repeat (32) @(posedge clock);
        wait_slot(1, 4);
        chk("pre-rst anodes", 16'(bus.digit_en_n), 16'hD);
        chk("pre-rst seg",    16'(bus.seg),        16'(S5));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst anodes", 16'(bus.digit_en_n), 16'hF);
        chk("async rst seg",    16'(bus.seg),        16'(SB));
        chk("async rst value",  bus.value,           16'h0000);
        chk("async rst wrap",   16'(bus.wrap),       16'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("restart gap anodes", 16'(bus.digit_en_n), 16'hF);
        @(posedge clock);
        #1;
        chk("restart d0 anodes", 16'(bus.digit_en_n), 16'hE);
        chk("restart d0 seg",    16'(bus.seg),        16'(S0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Four-digit BCD event counter with a time-multiplexed seven-segment scan controller. The counter holds the value, and the controller shares one segment bus across four common-anode digits. It advances the value by a fixed step on qualified requests, and sequences the digit drivers with a dead-time gap between digits to prevent ghosting. It also applies blanking and leading-zero suppression. It sits between the board-level event and push-button logic and the physical display pins.

## Interface
- SCAN_DIV, 1000: clock cycles per digit slot; must be ≥ 2.
- GAP_CYCLES, 4: dead-time cycles at the start of each slot, with all anodes off; must be < SCAN_DIV.
- STEP, 2: BCD increment per accepted advance, range 1..9.
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  qualifies advance.
- advance  input  1  one-cycle count request.
- clear  input  1  synchronous clear of the count to 0000.
- blanking  input  1  blanks the display, sampled at slot start.
- lz_suppress  input  1  enables leading-zero suppression.
- value  output  16  BCD count, {d3,d2,d1,d0}, where d0 is the units digit.
- wrap  output  1  one-cycle pulse when the count passes 9999.
- seg  output  7  active-low segments {a,b,c,d,e,f,g}.
- digit_en_n  output  4  active-low anodes; bit i drives digit i.

## Operation
- Segment encoding, {a..g} active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
  - Any BCD code above 9 decodes to blank.
- Counter:
  - On a clock edge with clear=1, value becomes 0000.
  - Otherwise, with advance=1 and enable=1, value becomes value+STEP in decimal, with per-digit BCD carry.
  - The sum wraps modulo 10000; for example, 9998+2 gives 0000 and 9999+2 gives 0001.
  - clear has priority over advance.
  - Back-to-back advances on consecutive cycles are each accepted.
- wrap is 1 for exactly one cycle, in the same cycle the wrapped value first appears on value. wrap is 0 when the count is cleared.
- Scan FSM states and transitions:
  - The slot counter sc runs 0..SCAN_DIV-1, and the digit index di runs 0→1→2→3→0.
  - GAP (sc < GAP_CYCLES): digit_en_n=1111 and seg=blank.
  - DRIVE (sc ≥ GAP_CYCLES): digit_en_n has bit di low and all other bits high; seg=decode(latched digit).
  - Transition GAP→DRIVE when sc reaches GAP_CYCLES.
  - Transition DRIVE→GAP at sc=SCAN_DIV-1; at the same edge sc returns to 0 and di increments.
- Slot latch: on the first cycle of each slot (sc=0), the controller captures:
  - the current value digit di;
  - the blank-above flag, meaning digits di+1..3 of value are all zero;
  - blanking.
  The count may change mid-slot; the visible digit does not change until the next slot.
- Slot blanking:
  - If latched blanking=1, the whole slot stays as in GAP, with anodes off and seg=blank.
  - If lz_suppress=1, di≠0, the latched digit is 0 and blank-above is set, the slot drives its anode with seg=blank.
  - Digit 0 is never suppressed.
- reset_n=0 forces every register to its reset state immediately, regardless of clock, including a reset mid-slot or mid-count:
  - value=0000, wrap=0, sc=0, di=0;
  - state=GAP, digit_en_n=1111, seg=1111111.

## Timing
- All outputs are registered, and there are no combinational paths from inputs to outputs.
- advance and clear have 1-cycle latency to value and wrap.
- Reset release:
  - The first rising edge after reset_n goes high is slot 0, sc=0, for digit 0.
  - The anode goes low at the edge where sc becomes GAP_CYCLES.
- Each digit is driven for SCAN_DIV-GAP_CYCLES cycles per slot, so a full frame is 4×SCAN_DIV cycles.
- Between any two anodes there are at least GAP_CYCLES cycles with digit_en_n=1111.
- A change on blanking or lz_suppress takes effect at the next slot start, within at most SCAN_DIV cycles.

## Test plan
All scenarios use SCAN_DIV=8 and GAP_CYCLES=2.
- Reset and scan: reset, release, idle 32 cycles.
  - Pattern per slot: 2 cycles with digit_en_n=1111 and seg=blank, then 6 cycles of 1110, 1101, 1011, 0111 in turn.
  - seg=0000001 for every slot.
- Count and wrap: apply 5000 advance pulses with enable=1 and STEP=2.
  - value goes 0002, 0004, …, 9998, 0000.
  - wrap pulses once, coincident with 0000.
  - A single pulse with enable=0 leaves value unchanged.
- Clear priority: load 0124, then assert clear and advance together.
  - Next cycle value=0000 and wrap=0.
- Leading-zero suppression: with value=0040 and lz_suppress=1:
  - digit 0 shows 0000001, digit 1 shows 1001100;
  - digits 2 and 3 have their anode low with seg=1111111.
  - With lz_suppress=0, digits 2 and 3 show 0000001.
- Mid-slot behaviour:
  - Assert blanking mid-slot: the current slot keeps driving, and the next slot has anodes at 1111 throughout.
  - Advance mid-slot: the visible digit is unchanged until the following slot start.
- Reset mid-operation: drop reset_n in DRIVE with value=0356.
  - Outputs are immediately 1111, 1111111, 0000, and wrap=0, before the next clock edge.
  - The scan restarts at digit 0 after release.
